// File: rtl/bcd_cntr_pkg.sv
// rtl/bcd_cntr_pkg.sv - shared BCD digit type, limits and legality helper
package bcd_cntr_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_is_illegal(input bcd_digit_t digit);
    return digit > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade: load, up/down count with wrap, terminal flag co
module bcd_digit
  import bcd_cntr_pkg::*;
(
  input  logic       CLK,
  input  logic       CDN,
  input  logic [3:0] d,
  input  logic       ld,
  input  logic       ce,
  input  logic       up,
  output logic [3:0] q,
  output logic       co
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (ce) begin
      if (up) begin
        q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      end else begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign co = up ? (q_q == BCD_MAX) : (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_updn_cntr.sv
// rtl/bcd_updn_cntr.sv - cascaded BCD up/down counter with load, TC and illegal-digit flag
// Optional build macro BCD_UPDN_CNTR_SELF_CORRECT_EN: count edges clear illegal digits.
module bcd_updn_cntr
  import bcd_cntr_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  CLK,
  input  logic                  CDN,
  input  logic [4*DIGITS-1:0]   D,
  input  logic                  LD,
  input  logic                  EN,
  input  logic                  CI,
  input  logic                  UP,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  TC,
  output logic                  ERR
);

  logic [DIGITS-1:0] co;
  logic [DIGITS-1:0] illegal;
  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] ld_dig;
  logic [4*DIGITS-1:0] d_dig;
  logic              count_en;

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      illegal[k] = bcd_is_illegal(Q[4*k +: 4]);
    end
  end

  assign ERR = |illegal;
  assign TC  = EN & CI & (&co);

`ifdef BCD_UPDN_CNTR_SELF_CORRECT_EN
  // Illegal digits are reloaded with zero and are transparent to the carry chain,
  // so the legal digits above them still step as if the lower digits had wrapped.
  assign count_en = EN & CI;

  always_comb begin
    carry[0] = count_en;
    for (int k = 1; k < DIGITS; k++) begin
      carry[k] = carry[k-1] & (co[k-1] | illegal[k-1]);
    end
  end

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      ld_dig[k] = LD | (count_en & illegal[k]);
    end
    d_dig = LD ? D : '0;
  end
`else
  assign count_en = EN & CI & ~ERR;

  always_comb begin
    carry[0] = count_en;
    for (int k = 1; k < DIGITS; k++) begin
      carry[k] = carry[k-1] & co[k-1];
    end
  end

  always_comb begin
    ld_dig = {DIGITS{LD}};
    d_dig  = D;
  end
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .CLK (CLK),
      .CDN (CDN),
      .d   (d_dig[4*k +: 4]),
      .ld  (ld_dig[k]),
      .ce  (carry[k]),
      .up  (UP),
      .q   (Q[4*k +: 4]),
      .co  (co[k])
    );
  end

endmodule

// File: tb/tb_bcd_updn_cntr.sv
// tb/tb_bcd_updn_cntr.sv - directed checks of bcd_updn_cntr with a two-instance cascade
module tb_bcd_updn_cntr;

  logic       CLK = 1'b0;
  logic       CDN;
  logic [7:0] D;
  logic       LD, EN, CI, UP;
  logic [7:0] Q;
  logic       TC, ERR;

  logic       c_cdn, c_en;
  logic [7:0] c_q_lo, c_q_hi;
  logic       c_tc_lo, c_tc_hi, c_err_lo, c_err_hi;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  bcd_updn_cntr #(.DIGITS(2)) dut (
    .CLK(CLK), .CDN(CDN), .D(D), .LD(LD), .EN(EN), .CI(CI), .UP(UP),
    .Q(Q), .TC(TC), .ERR(ERR)
  );

  bcd_updn_cntr #(.DIGITS(2)) u_lo (
    .CLK(CLK), .CDN(c_cdn), .D(8'h00), .LD(1'b0), .EN(c_en), .CI(1'b1), .UP(1'b1),
    .Q(c_q_lo), .TC(c_tc_lo), .ERR(c_err_lo)
  );

  bcd_updn_cntr #(.DIGITS(2)) u_hi (
    .CLK(CLK), .CDN(c_cdn), .D(8'h00), .LD(1'b0), .EN(c_en), .CI(c_tc_lo), .UP(1'b1),
    .Q(c_q_hi), .TC(c_tc_hi), .ERR(c_err_hi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [7:0] d, input logic en,
                       input logic ci, input logic up);
    LD = ld; D = d; EN = en; CI = ci; UP = up;
  endtask

  task automatic load(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
    tick();
    LD = 1'b0;
  endtask

  initial begin
    CDN = 1'b0; c_cdn = 1'b0; c_en = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #3;
    check("reset_q", Q, 8'h00);
    check("reset_err", ERR, 1'b0);
    check("reset_tc_idle", TC, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    #1;
    check("reset_tc_down", TC, 1'b1);
    tick();
    check("reset_hold_q", Q, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    CDN = 1'b1; c_cdn = 1'b1;

    // Up count through the 99 -> 00 wrap
    load(8'h98);
    check("ld_98", Q, 8'h98);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    #1;
    check("tc_at_98", TC, 1'b0);
    tick(); check("up_99", Q, 8'h99); check("tc_at_99", TC, 1'b1);
    tick(); check("up_00", Q, 8'h00); check("tc_at_00", TC, 1'b0);
    tick(); check("up_01", Q, 8'h01); check("tc_at_01", TC, 1'b0);

    // Asynchronous clear mid-count
    load(8'h47);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    #2;
    CDN = 1'b0;
    #1;
    check("async_clr_q", Q, 8'h00);
    check("async_clr_err", ERR, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    CDN = 1'b1;

    // Down count with borrow and 00 -> 99 wrap, then immediate direction change
    load(8'h10);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tick(); check("dn_09", Q, 8'h09);
    tick(); check("dn_08", Q, 8'h08);
    load(8'h00);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    #1;
    check("tc_dn_00", TC, 1'b1);
    tick(); check("dn_wrap_99", Q, 8'h99);
    check("tc_dn_99", TC, 1'b0);
    UP = 1'b1;
    tick(); check("updir_00", Q, 8'h00);

    // CI low holds the count; LD wins with EN low
    load(8'h55);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ci0_hold_q", Q, 8'h55);
      check("ci0_hold_tc", TC, 1'b0);
    end
    drive(1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
    tick(); check("ld_en0", Q, 8'h23);
    drive(1'b1, 8'h67, 1'b1, 1'b1, 1'b1);
    tick(); check("ld_over_count", Q, 8'h67);

    // Illegal digit handling
    load(8'h3C);
    check("ld_illegal", Q, 8'h3C);
    check("err_set", ERR, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
`ifdef BCD_UPDN_CNTR_SELF_CORRECT_EN
    check("illegal_count", Q, 8'h40);
    check("illegal_err_after", ERR, 1'b0);
`else
    check("illegal_count", Q, 8'h3C);
    check("illegal_err_after", ERR, 1'b1);
`endif
    load(8'h12);
    check("recover_q", Q, 8'h12);
    check("recover_err", ERR, 1'b0);

    // Two cascaded counters, 100 up edges from zero
    c_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
    end
    c_en = 1'b0;
    #1;
    check("casc_lo", c_q_lo, 8'h00);
    check("casc_hi", c_q_hi, 8'h01);
    check("casc_err", {c_err_hi, c_err_lo}, 2'b00);
    check("casc_tc", {c_tc_hi, c_tc_lo}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
